// File: rtl/clint_timer_if.sv
`timescale 1ns/1ps
// Register bus from soc_top's timer-window decode into clint_timer.
// One beat per cycle that bus_req is high; completion is a one-cycle bus_ack.
interface clint_timer_if #(
  parameter int ADDR_W = 5
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/clint_timer.sv
`timescale 1ns/1ps
// Machine timer (CLINT subset): prescaled 64-bit mtime, 64-bit mtimecmp and msip
// behind a fixed one-cycle-latency register bus; drives timer and software irqs.
module clint_timer #(
  parameter int PRESCALE = 4,
  parameter int ADDR_W   = 5
) (
  input  logic         clk,
  input  logic         reset,
  clint_timer_if.slave bus,
  output logic         timer_irq,
  output logic         soft_irq
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  localparam logic [ADDR_W-1:0] ADDR_MTIME_LO = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] ADDR_MTIME_HI = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] ADDR_CMP_LO   = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] ADDR_CMP_HI   = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] ADDR_MSIP     = ADDR_W'(32'h10);

  typedef enum logic [2:0] {
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MSIP,
    SEL_NONE
  } reg_sel_e;

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             tick;
  logic [63:0]      mtime_reg;
  logic [63:0]      mtime_next;
  logic [63:0]      mtime_inc;
  logic [63:0]      mtimecmp_reg;
  logic [63:0]      mtimecmp_next;
  logic             msip_reg;
  logic             msip_next;
  logic [31:0]      rdata_reg;
  logic [31:0]      rdata_next;
  logic             ack_reg;
  logic             timer_irq_reg;

  reg_sel_e         sel;
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       mtime_wr;
  logic [1:0]       cmp_wr;

  assign wr_en = bus.bus_req & bus.bus_we;
  assign rd_en = bus.bus_req & ~bus.bus_we;

  // Exact-match decode: unaligned or out-of-map addresses fall to SEL_NONE.
  always_comb begin
    sel = SEL_NONE;
    case (bus.bus_addr)
      ADDR_MTIME_LO: sel = SEL_MTIME_LO;
      ADDR_MTIME_HI: sel = SEL_MTIME_HI;
      ADDR_CMP_LO:   sel = SEL_CMP_LO;
      ADDR_CMP_HI:   sel = SEL_CMP_HI;
      ADDR_MSIP:     sel = SEL_MSIP;
      default:       sel = SEL_NONE;
    endcase
  end

  assign mtime_wr[0] = wr_en && (sel == SEL_MTIME_LO);
  assign mtime_wr[1] = wr_en && (sel == SEL_MTIME_HI);
  assign cmp_wr[0]   = wr_en && (sel == SEL_CMP_LO);
  assign cmp_wr[1]   = wr_en && (sel == SEL_CMP_HI);

  assign tick      = (cnt_reg == CNT_LAST);
  assign cnt_next  = tick ? '0 : cnt_reg + CNT_W'(1);
  assign mtime_inc = mtime_reg + 64'd1;

  // Any write to either mtime half suppresses that cycle's tick for all 64 bits,
  // so software never sees a carry it did not write.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign mtime_next[32*gi +: 32] = mtime_wr[gi] ? bus.bus_wdata :
                                       (|mtime_wr)  ? mtime_reg[32*gi +: 32] :
                                       tick         ? mtime_inc[32*gi +: 32] :
                                                      mtime_reg[32*gi +: 32];
      assign mtimecmp_next[32*gi +: 32] = cmp_wr[gi] ? bus.bus_wdata
                                                     : mtimecmp_reg[32*gi +: 32];
    end
  endgenerate

  assign msip_next = (wr_en && (sel == SEL_MSIP)) ? bus.bus_wdata[0] : msip_reg;

  // Reads see register contents before this cycle's tick or write lands.
  always_comb begin
    rdata_next = rdata_reg;
    if (rd_en) begin
      case (sel)
        SEL_MTIME_LO: rdata_next = mtime_reg[31:0];
        SEL_MTIME_HI: rdata_next = mtime_reg[63:32];
        SEL_CMP_LO:   rdata_next = mtimecmp_reg[31:0];
        SEL_CMP_HI:   rdata_next = mtimecmp_reg[63:32];
        SEL_MSIP:     rdata_next = {31'd0, msip_reg};
        default:      rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      mtime_reg     <= 64'd0;
      mtimecmp_reg  <= 64'd0;
      msip_reg      <= 1'b0;
      rdata_reg     <= 32'd0;
      ack_reg       <= 1'b0;
      timer_irq_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      mtime_reg     <= mtime_next;
      mtimecmp_reg  <= mtimecmp_next;
      msip_reg      <= msip_next;
      rdata_reg     <= rdata_next;
      ack_reg       <= bus.bus_req;
      timer_irq_reg <= (mtime_reg >= mtimecmp_reg);
    end
  end

  assign bus.bus_rdata = rdata_reg;
  assign bus.bus_ack   = ack_reg;
  assign timer_irq     = timer_irq_reg;
  assign soft_irq      = msip_reg;

endmodule

// File: tb/tb_clint_timer.sv
`timescale 1ns/1ps
// Bench for clint_timer: table of register accesses plus hand sequences for
// prescaler timing, carries, tick/write collisions, irq timing and mid-access reset.
module tb_clint_timer;
  localparam int P  = 4;
  localparam int AW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic timer_irq;
  logic soft_irq;

  clint_timer_if #(.ADDR_W(AW)) bus_if ();

  clint_timer #(.PRESCALE(P), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } sb_t;

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        req_at_edge = 1'b0;
  logic [31:0] last_rdata = 32'd0;
  logic        exp_ack;
  sb_t         mon_e;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] lo, input logic [63:0] hi);
    checks++;
    if ($isunknown(act) || act < lo || act > hi) begin
      errors++;
      if (lo == hi)
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, lo);
      else
        $display("FAIL %s: got 0x%0h, expected 0x%0h..0x%0h", name, act, lo, hi);
    end
  endtask

  function automatic void add_vec(input bit we, input logic [AW-1:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp,
                                  input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  // Cycles since reset release; the prescaler phase is cyc % P.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc         <= 0;
      req_at_edge <= 1'b0;
    end else begin
      cyc         <= cyc + 1;
      req_at_edge <= bus_if.bus_req;
    end
  end

  always @(negedge reset) begin
    sb_q.delete();
    last_rdata = 32'd0;
  end

  // Every request sampled with reset high must be acked exactly one cycle later.
  always @(negedge clk) begin
    exp_ack = req_at_edge && reset;
    check("ack_timing", bus_if.bus_ack, exp_ack, exp_ack);
    if (bus_if.bus_ack && exp_ack) begin
      check("sb_nonempty", 64'(sb_q.size()), 1, 1000);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_read) begin
          check(mon_e.name, bus_if.bus_rdata, mon_e.lo, mon_e.hi);
          last_rdata = bus_if.bus_rdata;
          $display("%0t rd %s rdata=0x%08h", $time, mon_e.name, bus_if.bus_rdata);
        end else begin
          check({mon_e.name, "_rdata_hold"}, bus_if.bus_rdata, last_rdata, last_rdata);
          $display("%0t wr %s acked, rdata=0x%08h", $time, mon_e.name, bus_if.bus_rdata);
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] lo, input logic [31:0] hi, input string name);
    sb_t e;
    @(posedge clk); #1;
    bus_if.bus_req   = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wdata;
    e.is_read = !we; e.lo = lo; e.hi = hi; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus_if.bus_req = 1'b0;
    end
  endtask

  // Returns so that the next issue() is sampled on a prescaler tick edge.
  task automatic sync_to_tick();
    for (int i = 0; i < P + 1; i++) begin
      @(posedge clk); #1;
      bus_if.bus_req = 1'b0;
      if ((cyc + 1) % P == P - 1) break;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp40;
    int n;
    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = 32'd0;

    add_vec(0, 5'h08, 32'h0,          32'h0,          "cmp_lo_reset");
    add_vec(0, 5'h0C, 32'h0,          32'h0,          "cmp_hi_reset");
    add_vec(0, 5'h08, 32'h0,          32'h0,          "cmp_lo_before_wr");
    add_vec(1, 5'h08, 32'h3030_3035,  32'h0,          "wr_cmp_lo");
    add_vec(0, 5'h08, 32'h0,          32'h3030_3035,  "cmp_lo_after_wr");
    add_vec(0, 5'h0C, 32'h0,          32'h0,          "cmp_hi_untouched");
    add_vec(1, 5'h0C, 32'h1234_5678,  32'h0,          "wr_cmp_hi");
    add_vec(0, 5'h0C, 32'h0,          32'h1234_5678,  "cmp_hi_after_wr");
    add_vec(1, 5'h0C, 32'h0,          32'h0,          "wr_cmp_hi_zero");
    add_vec(0, 5'h0C, 32'h0,          32'h0,          "cmp_hi_zero");
    add_vec(0, 5'h10, 32'h0,          32'h0,          "msip_reset");
    add_vec(1, 5'h10, 32'hFFFF_FFFF,  32'h0,          "wr_msip_all");
    add_vec(0, 5'h10, 32'h0,          32'h1,          "msip_bit0_only");
    add_vec(1, 5'h10, 32'hFFFF_FFFE,  32'h0,          "wr_msip_clear");
    add_vec(0, 5'h10, 32'h0,          32'h0,          "msip_cleared");
    add_vec(0, 5'h14, 32'h0,          32'h0,          "unmapped_14");
    add_vec(1, 5'h14, 32'hDEAD_BEEF,  32'h0,          "wr_unmapped_14");
    add_vec(0, 5'h14, 32'h0,          32'h0,          "unmapped_14_again");
    add_vec(0, 5'h09, 32'h0,          32'h0,          "unaligned_09");
    add_vec(1, 5'h0A, 32'hFFFF_FFFF,  32'h0,          "wr_unaligned_0a");
    add_vec(0, 5'h08, 32'h0,          32'h3030_3035,  "cmp_lo_kept");
    add_vec(0, 5'h1C, 32'h0,          32'h0,          "unmapped_1c");

    // Reset window and first cycle after release.
    #20;
    check("rst_timer_irq", timer_irq, 0, 0);
    check("rst_soft_irq", soft_irq, 0, 0);
    check("rst_ack", bus_if.bus_ack, 0, 0);
    check("rst_rdata", bus_if.bus_rdata, 0, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("irq_after_release", timer_irq, 1, 1);

    foreach (vecs[i])
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].exp, vecs[i].name);
    idle(2);

    // Prescaled counting over 40 clocks.
    exp40 = 40 / P;
    issue(1, 5'h00, 32'h0, 0, 0, "wr_mtime_lo0");
    issue(1, 5'h04, 32'h0, 0, 0, "wr_mtime_hi0");
    idle(40);
    issue(0, 5'h00, 0, (exp40 > 0) ? exp40 - 1 : 0, exp40 + 1, "mtime_lo_40clk");
    issue(0, 5'h04, 0, 0, 0, "mtime_hi_40clk");

    // Carry from low half into high half, then full 64-bit wrap.
    issue(1, 5'h00, 32'hFFFF_FFFF, 0, 0, "wr_lo_ones");
    issue(1, 5'h04, 32'h0,         0, 0, "wr_hi_zero");
    idle(P);
    issue(0, 5'h00, 0, 32'h0, 32'h0, "carry_lo");
    issue(0, 5'h04, 0, 32'h1, 32'h1, "carry_hi");
    issue(1, 5'h00, 32'hFFFF_FFFF, 0, 0, "wr_lo_ones2");
    issue(1, 5'h04, 32'hFFFF_FFFF, 0, 0, "wr_hi_ones");
    idle(P);
    issue(0, 5'h00, 0, 32'h0, 32'h0, "wrap_lo");
    issue(0, 5'h04, 0, 32'h0, 32'h0, "wrap_hi");

    // Write landing on a tick edge keeps the written value exactly.
    issue(1, 5'h04, 32'h5, 0, 0, "wr_hi_5");
    sync_to_tick();
    issue(1, 5'h00, 32'h1234, 0, 0, "wr_lo_on_tick");
    issue(0, 5'h00, 0, 32'h1234, 32'h1234, "lo_tick_dropped");
    issue(0, 5'h04, 0, 32'h5, 32'h5, "hi_unchanged");
    idle(1);

    // Timer interrupt: below compare, rise at 200, clear by raising mtimecmp.
    issue(1, 5'h0C, 32'h0,   0, 0, "wr_cmp_hi0");
    issue(1, 5'h08, 32'd200, 0, 0, "wr_cmp_lo200");
    issue(1, 5'h04, 32'h0,   0, 0, "wr_mtime_hi0b");
    issue(1, 5'h00, 32'd100, 0, 0, "wr_mtime_lo100");
    idle(3);
    check("irq_below_cmp", timer_irq, 0, 0);
    n = 0;
    while (!timer_irq && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise", timer_irq, 1, 1);
    issue(0, 5'h00, 0, 32'd200, 32'd200 + 32'(2 / P), "mtime_at_irq");
    issue(1, 5'h0C, 32'h1, 0, 0, "wr_cmp_hi1");
    idle(1);
    check("irq_one_cycle_lag", timer_irq, 1, 1);
    idle(1);
    check("irq_cleared", timer_irq, 0, 0);

    // Software interrupt follows msip one cycle after the write.
    check("soft_irq_pre", soft_irq, 0, 0);
    issue(1, 5'h10, 32'h1, 0, 0, "wr_msip_set");
    check("soft_irq_not_yet", soft_irq, 0, 0);
    idle(1);
    check("soft_irq_set", soft_irq, 1, 1);

    // Reset in the middle of back-to-back reads.
    issue(1, 5'h0C, 32'h0, 0, 0, "wr_cmp_hi_clr");
    issue(1, 5'h08, 32'h0, 0, 0, "wr_cmp_lo_clr");
    idle(3);
    check("irq_pre_reset", timer_irq, 1, 1);
    issue(0, 5'h10, 0, 32'h1, 32'h1, "msip_pre_reset");
    issue(0, 5'h00, 0, 32'h0, 32'hFFFF_FFFF, "mtime_inflight");
    #1;
    check("ack_before_reset", bus_if.bus_ack, 1, 1);
    reset = 1'b0;
    bus_if.bus_req = 1'b0;
    #1;
    check("mid_rst_ack", bus_if.bus_ack, 0, 0);
    check("mid_rst_rdata", bus_if.bus_rdata, 0, 0);
    check("mid_rst_timer_irq", timer_irq, 0, 0);
    check("mid_rst_soft_irq", soft_irq, 0, 0);
    repeat (3) @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    check("irq_after_rerelease", timer_irq, 1, 1);
    issue(0, 5'h08, 0, 32'h0, 32'h0, "cmp_lo_after_rst");
    issue(0, 5'h10, 0, 32'h0, 32'h0, "msip_after_rst");
    issue(0, 5'h14, 0, 32'h0, 32'h0, "unmapped_after_rst");
    idle(3);
    check("sb_drained", 64'(sb_q.size()), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
